fc_argmax: RTL and testbench
============================

Name: fc_argmax

Overview:
- Classification head that sits directly downstream of the combinational Q8.8 fully-connected output layer.
- Captures one vector of OC signed Q8.8 class scores under a valid/ready handshake.
- Scans the scores serially, one comparison per clock, and returns the winning class index and its score under a second valid/ready handshake.
- Gives the classifier a registered, timing-friendly boundary to the UART/display side of the OCR design.

Parameters:
- OC, 10, number of classes / scores; legal range 1..1024.
- CW, (OC>1 ? $clog2(OC) : 1), width of the class index; derived, never overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  score vector on in_scores is valid.
- in_ready  output  1  block can accept a vector; high only in IDLE.
- in_scores  input  16 x OC (signed, unpacked [0:OC-1])  Q8.8 class scores.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- out_class  output  CW  index of the maximum score.
- out_score  output  16 signed  maximum score, Q8.8.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, in_ready=1, out_valid=0, out_class=0, out_score=0, scan index=0.
  - Reset wins over every other event, including reset mid-SCAN or in DONE with out_ready=1; any partial result is discarded.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register all OC scores into an internal array; best=score[0]; best_idx=0; i=1.
  - Next state is SCAN if OC>1, otherwise DONE.
  - in_scores is sampled only on the accept edge, so upstream may change it afterwards.
- SCAN:
  - in_ready=0.
  - Each cycle compare the registered score[i] with best using a signed compare.
  - Replace best/best_idx only if score[i] > best (strictly greater), so ties resolve to the lowest index.
  - When i==OC-1, go to DONE after that compare; otherwise i=i+1.
- DONE:
  - out_valid=1; out_class=best_idx; out_score=best.
  - All three are stable while out_ready=0.
  - On out_valid&&out_ready, go to IDLE and drop out_valid.
  - out_class and out_score keep their last values after the handshake until the next result.
- Latency:
  - Vector accepted at edge k → out_valid high after edge k+OC-1.
  - OC=1 → high after edge k+1.
- Throughput: one vector per OC+1 cycles minimum, with no overlap; in_ready stays low from accept until the result handshake completes.
- Arithmetic:
  - Compares are full 16-bit signed.
  - -32768 (0x8000) is a legal score.
  - No saturation needed; the block does no arithmetic on scores.
- in_valid while in_ready=0: ignored, not queued.
- out_ready while out_valid=0: no effect.

Optional Feature:
- Macro: FC_ARGMAX_MARGIN_EN.
- Defined:
  - Adds output port out_margin, 16 bits unsigned, valid with out_valid.
  - Tracks second-best: second initialises to 0x8000.
  - Update rule: if s>best then second=best and best=s; else if s>second then second=s.
  - out_margin = best-second. It is always ≥0 and fits in 16 bits unsigned.
  - OC=1 → 0. A tie for maximum → 0.
  - out_margin resets to 0.
- Undefined: no port, no second-best register; timing and behaviour otherwise identical.

Decomposition:
- Shared package bnn_pkg:
  - typedef score_t (logic signed [15:0], Q8.8).
  - localparam NUM_CLASSES = 10.
  - localparam SCORE_MIN = 16'sh8000.
  - The state enum typedef stays local to this module.
- No sub-module is needed. The FSM, score register array, index counter and comparator form one module. The comparator is a single always_comb.

Test Plan:
- Reset then OC=10 scores {0x0100,0x0200,0xFF00,0x0050,0x0300,0x0000,0x0010,0x0020,0x0030,0x0040}, out_ready=1 → out_valid after edge k+9, out_class=4, out_score=0x0300, in_ready returns high the next cycle.
- All scores 0x8000 → out_class=0, out_score=0x8000. Scores equal 0x0100 at indices 3 and 7, others lower → out_class=3. With FC_ARGMAX_MARGIN_EN, the tie case gives out_margin=0.
- Backpressure: hold out_ready=0 for 20 cycles in DONE, toggling in_valid and in_scores → outputs unchanged, in_ready=0, the new vector is not accepted; release out_ready → IDLE, then the next vector is accepted.
- Reset asserted during SCAN (at i=5), then a fresh vector with a maximum at index 9 of 0x7FFF → first result is class 9 / 0x7FFF, with no residue from the aborted scan.
- Change in_scores the cycle after accept → result reflects only the captured vector.
- FC_ARGMAX_MARGIN_EN with scores {0x0100,0x0400,0x0380, rest 0xF000} → out_class=1, out_margin=0x0080.
- OC=1 build with score 0xFF80 → out_valid after edge k+1, out_class=0, out_score=0xFF80, out_margin=0.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types and constants for the binarised-network OCR datapath.
// Scores are signed Q8.8 values carried in a 16-bit container.
package bnn_pkg;

  typedef logic signed [15:0] score_t;

  localparam int     NUM_CLASSES = 10;
  localparam score_t SCORE_MIN   = 16'sh8000;

endpackage : bnn_pkg

// File: rtl/fc_argmax.sv
// fc_argmax: serial argmax over one vector of OC signed Q8.8 class scores.
// A vector is captured on the input handshake. The block then makes one
// compare per clock. The winning index and score are held on the output
// handshake until they are accepted.
// Optional build macro FC_ARGMAX_MARGIN_EN adds out_margin. This is the
// best score minus the second-best score, with ties for the maximum
// giving 0.
module fc_argmax
  import bnn_pkg::*;
#(
  parameter  int OC = NUM_CLASSES,
  localparam int CW = (OC > 1) ? $clog2(OC) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  score_t        in_scores [0:OC-1],
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_class,
  output score_t        out_score
`ifdef FC_ARGMAX_MARGIN_EN
  ,
  output logic [15:0]   out_margin
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(OC - 1);

  state_t        state;
  score_t        scores [0:OC-1];
  score_t        best;
  logic [CW-1:0] best_idx;
  logic [CW-1:0] idx;

  logic          accept;
  score_t        cand;
  logic          take;
  score_t        best_nx;
  logic [CW-1:0] best_idx_nx;

`ifdef FC_ARGMAX_MARGIN_EN
  score_t        second;
  score_t        second_nx;
  logic [15:0]   margin_nx;
`endif

  assign accept = in_valid && in_ready;

  // Comparator: strictly-greater signed compare, so ties keep the lower index
  always_comb begin
    cand        = scores[idx];
    take        = cand > best;
    best_nx     = take ? cand : best;
    best_idx_nx = take ? idx : best_idx;
`ifdef FC_ARGMAX_MARGIN_EN
    second_nx = second;
    if (take) begin
      second_nx = best;
    end else if (cand > second) begin
      second_nx = cand;
    end
    margin_nx = best_nx - second_nx;
`endif
  end

  // Score array captures the whole vector only on the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < OC; k++) begin
        scores[k] <= in_scores[k];
      end
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_class <= '0;
      out_score <= '0;
      idx       <= '0;
      best      <= '0;
      best_idx  <= '0;
`ifdef FC_ARGMAX_MARGIN_EN
      second     <= SCORE_MIN;
      out_margin <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            best     <= in_scores[0];
            best_idx <= '0;
            in_ready <= 1'b0;
`ifdef FC_ARGMAX_MARGIN_EN
            second <= SCORE_MIN;
`endif
            if (OC > 1) begin
              idx   <= CW'(1);
              state <= SCAN;
            end else begin
              idx   <= '0;
              state <= DONE;
            end
          end
        end

        SCAN: begin
          best     <= best_nx;
          best_idx <= best_idx_nx;
`ifdef FC_ARGMAX_MARGIN_EN
          second <= second_nx;
`endif
          if (idx == LAST_IDX) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_class <= best_idx_nx;
            out_score <= best_nx;
`ifdef FC_ARGMAX_MARGIN_EN
            out_margin <= margin_nx;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          if (!out_valid) begin
            // Single-class build arrives here with no scan, so publish one edge later
            out_valid <= 1'b1;
            out_class <= best_idx;
            out_score <= best;
`ifdef FC_ARGMAX_MARGIN_EN
            out_margin <= '0;
`endif
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            idx       <= '0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          idx       <= '0;
        end
      endcase
    end
  end

endmodule : fc_argmax

// File: tb/tb_fc_argmax.sv
// Testbench for fc_argmax: directed and random vectors are checked against
// a plain argmax / second-best reference. A separate OC=1 instance covers
// the single-class build.
module tb_fc_argmax;
  import bnn_pkg::*;

  localparam int OC = NUM_CLASSES;
  localparam int CW = $clog2(OC);

  typedef score_t vec_t [0:OC-1];

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  score_t        in_scores [0:OC-1];
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_class;
  score_t        out_score;

  logic          in1_valid;
  logic          in1_ready;
  score_t        in1_scores [0:0];
  logic          out1_valid;
  logic          out1_ready;
  logic [0:0]    out1_class;
  score_t        out1_score;

`ifdef FC_ARGMAX_MARGIN_EN
  logic [15:0]   out_margin;
  logic [15:0]   out1_margin;
`endif

  int nAsserts;
  int nFails;

  fc_argmax #(.OC(OC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_scores (in_scores),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score)
`ifdef FC_ARGMAX_MARGIN_EN
    ,
    .out_margin(out_margin)
`endif
  );

  fc_argmax #(.OC(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in1_valid),
    .in_ready  (in1_ready),
    .in_scores (in1_scores),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .out_class (out1_class),
    .out_score (out1_score)
`ifdef FC_ARGMAX_MARGIN_EN
    ,
    .out_margin(out1_margin)
`endif
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: first index of the maximum, and the margin to the best of the rest
  task automatic refModel(input vec_t v, output int cls, output score_t best, output logic [15:0] margin);
    int sec;
    cls = 0;
    for (int i = 1; i < OC; i++) begin
      if (int'(v[i]) > int'(v[cls])) cls = i;
    end
    best = v[cls];
    sec  = -32768;
    for (int i = 0; i < OC; i++) begin
      if (i != cls && int'(v[i]) > sec) sec = int'(v[i]);
    end
    margin = (OC == 1) ? 16'd0 : 16'(int'(best) - sec);
  endtask

  function automatic vec_t randVec(input int mode);
    vec_t v;
    for (int i = 0; i < OC; i++) begin
      if (mode == 0) v[i] = score_t'($urandom);
      else           v[i] = score_t'($urandom_range(0, 3) << 8);
    end
    return v;
  endfunction

  // Offer a vector, wait for the accept edge, then scramble the bus
  task automatic applyStimulus(input vec_t v, input string tag);
    int waitCnt;
    waitCnt   = 0;
    in_scores = v;
    in_valid  = 1'b1;
    while (!in_ready && waitCnt < 100) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkEq({tag, "_accept_wait"}, 32'(waitCnt < 100), 32'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_scores = randVec(0);
  endtask

  // Wait for the result, check it (optionally under backpressure), then hand it off
  task automatic checkOutput(input vec_t v, input string tag, input int holdCycles);
    int          cls;
    score_t      best;
    logic [15:0] margin;
    int          lat;
    refModel(v, cls, best, margin);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checkEq({tag, "_latency"}, 32'(lat), 32'(OC - 1));
    checkEq({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    checkEq({tag, "_class"}, 32'(out_class), 32'(cls));
    checkEq({tag, "_score"}, 32'(out_score), 32'(best));
`ifdef FC_ARGMAX_MARGIN_EN
    checkEq({tag, "_margin"}, 32'(out_margin), 32'(margin));
`endif
    for (int c = 0; c < holdCycles; c++) begin
      out_ready = 1'b0;
      in_valid  = c[0];
      in_scores = randVec(0);
      @(posedge clk); #1;
      checkEq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      checkEq({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      checkEq({tag, "_hold_class"}, 32'(out_class), 32'(cls));
      checkEq({tag, "_hold_score"}, 32'(out_score), 32'(best));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkEq({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    checkEq({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    checkEq({tag, "_class_kept"}, 32'(out_class), 32'(cls));
    checkEq({tag, "_score_kept"}, 32'(out_score), 32'(best));
  endtask

  // Directed sequence followed by a random sweep
  initial begin
    vec_t v;
    nAsserts      = 0;
    nFails        = 0;
    rst           = 1'b1;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    in_scores     = randVec(0);
    in1_valid     = 1'b0;
    out1_ready    = 1'b0;
    in1_scores[0] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] reset released");

    checkEq("rst_in_ready", 32'(in_ready), 32'd1);
    checkEq("rst_out_valid", 32'(out_valid), 32'd0);
    checkEq("rst_out_class", 32'(out_class), 32'd0);
    checkEq("rst_out_score", 32'(out_score), 32'd0);
`ifdef FC_ARGMAX_MARGIN_EN
    checkEq("rst_out_margin", 32'(out_margin), 32'd0);
`endif

    v = '{16'sh0100, 16'sh0200, 16'shFF00, 16'sh0050, 16'sh0300,
          16'sh0000, 16'sh0010, 16'sh0020, 16'sh0030, 16'sh0040};
    out_ready = 1'b1;
    applyStimulus(v, "basic");
    checkEq("basic_no_early_valid", 32'(out_valid), 32'd0);
    checkOutput(v, "basic", 0);

    for (int i = 0; i < OC; i++) v[i] = SCORE_MIN;
    applyStimulus(v, "allmin");
    checkOutput(v, "allmin", 0);

    for (int i = 0; i < OC; i++) v[i] = score_t'(16'h0050 + i);
    v[3] = 16'sh0100;
    v[7] = 16'sh0100;
    applyStimulus(v, "tie");
    checkOutput(v, "tie", 0);

    v = randVec(0);
    applyStimulus(v, "bp");
    checkOutput(v, "bp", 20);
    v = randVec(0);
    applyStimulus(v, "after_bp");
    checkOutput(v, "after_bp", 0);

    v = randVec(0);
    applyStimulus(v, "abort");
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkEq("abort_in_ready", 32'(in_ready), 32'd1);
    checkEq("abort_out_valid", 32'(out_valid), 32'd0);
    checkEq("abort_out_class", 32'(out_class), 32'd0);
    checkEq("abort_out_score", 32'(out_score), 32'd0);
    v = randVec(0);
    v[9] = 16'sh7FFF;
    applyStimulus(v, "fresh");
    checkOutput(v, "fresh", 0);

    for (int i = 0; i < OC; i++) v[i] = 16'shF000;
    v[0] = 16'sh0100;
    v[1] = 16'sh0400;
    v[2] = 16'sh0380;
    applyStimulus(v, "margin");
    checkOutput(v, "margin", 0);

    for (int n = 0; n < 8; n++) begin
      v = randVec(n % 2);
      applyStimulus(v, "rand");
      checkOutput(v, "rand", (n == 3) ? 3 : 0);
    end

    in1_scores[0] = 16'shFF80;
    in1_valid     = 1'b1;
    checkEq("oc1_in_ready", 32'(in1_ready), 32'd1);
    @(posedge clk); #1;
    in1_valid     = 1'b0;
    in1_scores[0] = 16'sh1234;
    checkEq("oc1_no_early_valid", 32'(out1_valid), 32'd0);
    @(posedge clk); #1;
    checkEq("oc1_valid", 32'(out1_valid), 32'd1);
    checkEq("oc1_class", 32'(out1_class), 32'd0);
    checkEq("oc1_score", 32'(out1_score), 32'(score_t'(16'shFF80)));
`ifdef FC_ARGMAX_MARGIN_EN
    checkEq("oc1_margin", 32'(out1_margin), 32'd0);
`endif
    out1_ready = 1'b1;
    @(posedge clk); #1;
    out1_ready = 1'b0;
    checkEq("oc1_valid_drop", 32'(out1_valid), 32'd0);
    checkEq("oc1_in_ready_back", 32'(in1_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule : tb_fc_argmax
